// File: rtl/tt_um_jimktrains_vslc_eeprom_writer.sv
// Single-byte writer for a 25xx-style SPI EEPROM (mode 0, 16-bit address).
// Sequence: WREN, CS gap, WRITE+addr+data, CS gap, RDSR, then status polling
// until WIP clears. The state, the bit counter and copi change on negedge clk,
// and cipo is sampled on posedge clk. clk also drives the EEPROM SCK.
// Optional macro EEPROM_WRITER_POLL_TIMEOUT_EN bounds polling to POLL_LIMIT
// status bytes. When the limit is hit it raises error.
module tt_um_jimktrains_vslc_eeprom_writer #(
   parameter int POLL_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] address,
   input  logic [7:0]  data,
   input  logic        hold_n,
   input  logic        cipo,
   output logic        copi,
   output logic        chip_select_n,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  status_byte
);

   typedef enum logic [3:0] {
      IDLE, WREN, GAP1, WRITE, ADDR, DATA, GAP2, RDSR, STAT, DONE
   } state_t;

   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_RDSR  = 8'h05;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [15:0] addr_q;
   logic [7:0]  data_q;
   logic        accept;
   logic        timeout;

`ifdef EEPROM_WRITER_POLL_TIMEOUT_EN
   localparam int PW = $clog2(POLL_LIMIT + 1);
   logic [PW-1:0] poll_cnt;
   logic          err_q;

   // Give up when the byte that just finished reaches the limit and still shows WIP.
   assign timeout = (state == STAT) && (cnt == 4'd0) && status_byte[0] &&
                    ((int'(poll_cnt) + 1) >= POLL_LIMIT);
   assign error   = err_q;

   // Count completed status bytes while in STAT. Error is sticky until the next accepted start.
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         poll_cnt <= '0;
         err_q    <= 1'b0;
      end else if (hold_n) begin
         if (accept)       err_q <= 1'b0;
         else if (timeout) err_q <= 1'b1;
         if (state != STAT)      poll_cnt <= '0;
         else if (cnt == 4'd0)   poll_cnt <= poll_cnt + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   // Register the state, the counter and the captured request on the SCK falling edge. Hold freezes them.
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= 4'd7;
         addr_q <= '0;
         data_q <= '0;
      end else if (hold_n) begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            addr_q <= address;
            data_q <= data;
         end
      end
   end

   // Shift the status register in on the SCK rising edge, MSB first.
   always_ff @(posedge clk) begin
      if (!rst_n)
         status_byte <= '0;
      else if (hold_n && state == STAT)
         status_byte[cnt[2:0]] <= cipo;
   end

   // Compute the next state, the next counter value and the serial outputs for the current state.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      accept        = 1'b0;
      chip_select_n = 1'b1;
      copi          = 1'b0;
      busy          = (state != IDLE);
      done          = (state == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = WREN;
               cnt_nxt   = 4'd7;
            end
         end
         WREN: begin
            chip_select_n = 1'b0;
            copi          = OP_WREN[cnt[2:0]];
            if (cnt == 4'd0) state_nxt = GAP1;
            else             cnt_nxt   = cnt - 4'd1;
         end
         GAP1: begin
            state_nxt = WRITE;
            cnt_nxt   = 4'd7;
         end
         WRITE: begin
            chip_select_n = 1'b0;
            copi          = OP_WRITE[cnt[2:0]];
            if (cnt == 4'd0) begin
               state_nxt = ADDR;
               cnt_nxt   = 4'd15;
            end else cnt_nxt = cnt - 4'd1;
         end
         ADDR: begin
            chip_select_n = 1'b0;
            copi          = addr_q[cnt];
            if (cnt == 4'd0) begin
               state_nxt = DATA;
               cnt_nxt   = 4'd7;
            end else cnt_nxt = cnt - 4'd1;
         end
         DATA: begin
            chip_select_n = 1'b0;
            copi          = data_q[cnt[2:0]];
            if (cnt == 4'd0) state_nxt = GAP2;
            else             cnt_nxt   = cnt - 4'd1;
         end
         GAP2: begin
            // CS high here commits the write inside the EEPROM.
            state_nxt = RDSR;
            cnt_nxt   = 4'd7;
         end
         RDSR: begin
            chip_select_n = 1'b0;
            copi          = OP_RDSR[cnt[2:0]];
            if (cnt == 4'd0) begin
               state_nxt = STAT;
               cnt_nxt   = 4'd7;
            end else cnt_nxt = cnt - 4'd1;
         end
         STAT: begin
            // CS stays low, so the EEPROM keeps streaming the status register.
            chip_select_n = 1'b0;
            if (cnt == 4'd0) begin
               if (!status_byte[0] || timeout) state_nxt = DONE;
               else                            cnt_nxt   = 4'd7;
            end else cnt_nxt = cnt - 4'd1;
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd7;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd7;
         end
      endcase
   end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_eeprom_writer.sv
// Randomized bench for the EEPROM writer. An SPI slave model captures each
// CS-low frame and answers RDSR with a scripted sequence of status bytes.
// Expected frames, latency, status and error come from the protocol rules.
module tb_tt_um_jimktrains_vslc_eeprom_writer;

`ifdef EEPROM_WRITER_POLL_TIMEOUT_EN
   localparam int  LIM    = 4;
   localparam bit  TO_EN  = 1'b1;
`else
   localparam int  LIM    = 255;
   localparam bit  TO_EN  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, hold_n, cipo;
   logic [15:0] address;
   logic [7:0]  data;
   logic        copi, chip_select_n, busy, done, error;
   logic [7:0]  status_byte;

   tt_um_jimktrains_vslc_eeprom_writer #(.POLL_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .address(address), .data(data),
      .hold_n(hold_n), .cipo(cipo), .copi(copi), .chip_select_n(chip_select_n),
      .busy(busy), .done(done), .error(error), .status_byte(status_byte)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // SPI slave model: frames observed on COPI and the scripted status bytes
   logic [7:0]  stat_vals [16];
   int          fq_len[$];
   logic [39:0] fq_bits[$];
   logic [7:0]  fq_op[$];
   int          fq_gap[$];
   int          fc = 0, gap = 0, cur_gap = 0;
   logic [39:0] fbits = '0;
   logic [7:0]  op = '0;

   initial cipo = 1'b0;

   always @(posedge clk) begin
      logic nb;
      nb = 1'b0;
      if (!rst_n) begin
         fc = 0; gap = 0;
      end else if (hold_n) begin
         if (!chip_select_n) begin
            if (fc == 0) cur_gap = gap;
            if (fc < 40) fbits = {fbits[38:0], copi};
            fc++;
            gap = 0;
            if (fc == 8) op = fbits[7:0];
            if (fc >= 8 && op == 8'h05) begin
               int s;
               s  = fc - 8;
               nb = (s / 8 < 16) ? stat_vals[s / 8][7 - (s % 8)] : 1'b0;
            end
         end else begin
            if (fc > 0) begin
               fq_len.push_back(fc); fq_bits.push_back(fbits);
               fq_op.push_back(op);  fq_gap.push_back(cur_gap);
            end
            fc = 0; fbits = '0; op = '0;
            gap++;
         end
         #1 cipo = nb;
      end
   end

   task automatic clear_frames();
      fq_len.delete(); fq_bits.delete(); fq_op.delete(); fq_gap.delete();
   endtask

   // One full write. wip = number of leading status bytes with WIP=1.
   task automatic run_txn(input logic [15:0] a, input logic [7:0] d, input int wip,
                          input int hold_at, input int stat_pulse, input bit zero_stat);
      int nb, exp_cyc, cyc, got;
      bit exp_err, hold_ok;
      logic hc, hs;
      nb      = wip + 1;
      exp_err = 1'b0;
      if (TO_EN && nb > LIM) begin nb = LIM; exp_err = 1'b1; end
      for (int k = 0; k < 16; k++) begin
         logic [7:0] v;
         v = zero_stat ? 8'h00 : 8'($urandom);
         v[0] = (k < wip);
         stat_vals[k] = v;
      end
      exp_cyc = 59 + 8 * (nb - 1) + ((hold_at > 0) ? 5 : 0);
      clear_frames();
      @(negedge clk); #1;
      start = 1'b1; address = a; data = d;
      cyc = 0; got = 0; hold_ok = 1'b1; hc = 1'b0; hs = 1'b0;
      while (cyc < 3000) begin
         @(negedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            start = 1'b0; address = 16'($urandom); data = 8'($urandom);
            chk("busy_on_accept", busy, 1'b1);
            chk("error_clr_on_accept", error, 1'b0);
         end
         if (hold_at > 0) begin
            if (cyc > hold_at && cyc <= hold_at + 5 && (copi !== hc || chip_select_n !== hs))
               hold_ok = 1'b0;
            if (cyc == hold_at) begin hc = copi; hs = chip_select_n; hold_n = 1'b0; end
            if (cyc == hold_at + 5) hold_n = 1'b1;
         end
         if (stat_pulse > 0) begin
            if (cyc == stat_pulse)     start = 1'b1;
            if (cyc == stat_pulse + 1) start = 1'b0;
         end
         if (done) begin got = cyc; break; end
      end
      chk("done_cycle", got, exp_cyc);
      if (hold_at > 0) chk("hold_static", hold_ok, 1'b1);
      chk("status_at_done", status_byte, stat_vals[nb-1]);
      chk("error_at_done", error, exp_err);
      chk("busy_at_done", busy, 1'b1);
      @(negedge clk); #1;
      chk("done_pulse_end", done, 1'b0);
      chk("busy_end", busy, 1'b0);
      chk("cs_idle", chip_select_n, 1'b1);
      @(negedge clk); #1;
      chk("frame_count", fq_len.size(), 3);
      if (fq_len.size() == 3) begin
         chk("wren_len", fq_len[0], 8);
         chk("wren_op", fq_op[0], 8'h06);
         chk("write_len", fq_len[1], 32);
         chk("write_bits", fq_bits[1][31:0], {8'h02, a, d});
         chk("gap1", fq_gap[1], 1);
         chk("rdsr_len", fq_len[2], 8 + 8 * nb);
         chk("rdsr_op", fq_op[2], 8'h05);
         chk("gap2", fq_gap[2], 1);
      end
      chk("error_holds", error, exp_err);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; hold_n = 1'b1; address = '0; data = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cs", chip_select_n, 1'b1);
      chk("rst_copi", copi, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_status", status_byte, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic write, then 3 busy polls, then hold mid-ADDR
      run_txn(16'h1234, 8'hA5, 0, 0, 0, 1'b1);
      run_txn(16'h1234, 8'hA5, 3, 0, 0, 1'b1);
      run_txn(16'h1234, 8'hA5, 0, 24, 0, 1'b1);

      // reset during DATA aborts the write
      begin
         int cyc;
         clear_frames();
         @(negedge clk); #1;
         start = 1'b1; address = 16'hBEEF; data = 8'h3C;
         for (cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 1) start = 1'b0;
         end
         rst_n = 1'b0;
         @(negedge clk); #1;
         chk("abort_cs", chip_select_n, 1'b1);
         chk("abort_busy", busy, 1'b0);
         chk("abort_done", done, 1'b0);
         @(negedge clk); #1;
         chk("abort_no_done", done, 1'b0);
         rst_n = 1'b1;
         repeat (2) @(negedge clk);
      end
      run_txn(16'hBEEF, 8'h3C, 1, 0, 0, 1'b0);

      // start pulsed in STAT is ignored; address input keeps changing after accept
      run_txn(16'h0F0F, 8'h81, 2, 0, 52, 1'b0);

      for (int i = 0; i < 8; i++) begin
         int w, h;
         w = TO_EN ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
         h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 50)) : 0;
         run_txn(16'($urandom), 8'($urandom), w, h, 0, 1'b0);
      end

      if (TO_EN) begin
         run_txn(16'h4321, 8'h5A, 10, 0, 0, 1'b0);
         run_txn(16'h4322, 8'h5B, 0, 0, 0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
